// File: rtl/gomoku_move_engine.sv
// gomoku_move_engine: scans a latched N x N Gomoku board one cell per clock,
// scores every empty cell for the CPU colour and reports the best move.
//
// Handshake: a start is a cycle with enable_export=1 while not busy. From the
// start edge busy_export=1 and ready_export=0. When the scan ends, busy_export
// drops and ready_export rises together. outx/outy/score/valid are stable while
// ready_export=1, and stay that way until the next start. valid_export=0 with
// ready_export=1 means the board had no empty cell.
module gomoku_move_engine #(
  parameter int BOARD_N = 8,
  parameter int COORD_W = 3,
  parameter int WIN_LEN = 5,
  parameter int SCORE_W = 16
) (
  input  logic                         clk_clk,
  input  logic                         reset_reset,
  input  logic                         enable_export,
  input  logic [2*BOARD_N*BOARD_N-1:0] board_export,
  input  logic [1:0]                   player_export,
  output logic [COORD_W-1:0]           outx_export,
  output logic [COORD_W-1:0]           outy_export,
  output logic [SCORE_W-1:0]           score_export,
  output logic                         valid_export,
  output logic                         ready_export,
  output logic                         busy_export
);

  localparam int BOARD_W = 2 * BOARD_N * BOARD_N;
  // Extra headroom so the unsaturated sum never wraps before the clamp.
  localparam int SUM_W   = SCORE_W + 3;
  localparam logic [SCORE_W-1:0] SCORE_WIN   = '1;
  localparam logic [SCORE_W-1:0] SCORE_BLOCK = {{(SCORE_W-1){1'b1}}, 1'b0};
  localparam logic [SCORE_W-1:0] SCORE_SAT   = {{(SCORE_W-2){1'b1}}, 2'b01};
  localparam logic [COORD_W-1:0] LAST_C      = COORD_W'(BOARD_N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [BOARD_W-1:0]   board_q, board_d;
  logic [1:0]           player_q, player_d;
  logic [COORD_W-1:0]   cx_q, cx_d;
  logic [COORD_W-1:0]   cy_q, cy_d;
  logic [COORD_W-1:0]   best_x_q, best_x_d;
  logic [COORD_W-1:0]   best_y_q, best_y_d;
  logic [SCORE_W-1:0]   best_score_q, best_score_d;
  logic                 best_valid_q, best_valid_d;

  logic                 cell_empty;
  logic                 any_win;
  logic                 any_block;
  logic [SUM_W-1:0]     base_sum;
  logic [SCORE_W-1:0]   cell_score;

  // Count consecutive stones of colour c starting one step from (x0,y0)
  // in direction (dx,dy); stops at the first other cell or the board edge.
  function automatic int run_len(input logic [BOARD_W-1:0] b, input int x0,
                                 input int y0, input int dx, input int dy,
                                 input logic [1:0] c, input logic c_en);
    int   n;
    int   xx;
    int   yy;
    logic go;
    n  = 0;
    go = c_en;
    for (int k = 1; k < WIN_LEN; k++) begin
      xx = x0 + k * dx;
      yy = y0 + k * dy;
      if (go && xx >= 0 && xx < BOARD_N && yy >= 0 && yy < BOARD_N) begin
        if (b[2*(yy*BOARD_N+xx) +: 2] == c) n = n + 1;
        else go = 1'b0;
      end else begin
        go = 1'b0;
      end
    end
    return n;
  endfunction

  // Score the cell under the scan pointer in the four line directions.
  always_comb begin
    logic       own_en;
    logic [1:0] own_c;
    logic [1:0] opp_c;
    logic [1:0] cur;
    int         x;
    int         y;
    int         dx;
    int         dy;
    int         r_own;
    int         r_opp;
    int         m_own;
    int         m_opp;
    // A colour of 00 or 11 means no stone on the board counts for either side.
    own_en     = (player_q == 2'b01) || (player_q == 2'b10);
    own_c      = player_q;
    opp_c      = ~player_q;
    x          = int'(cx_q);
    y          = int'(cy_q);
    cur        = board_q[2*(y*BOARD_N+x) +: 2];
    cell_empty = (cur == 2'b00);
    any_win    = 1'b0;
    any_block  = 1'b0;
    base_sum   = '0;
    for (int d = 0; d < 4; d++) begin
      case (d)
        0:       begin dx = 1; dy = 0;  end
        1:       begin dx = 0; dy = 1;  end
        2:       begin dx = 1; dy = 1;  end
        default: begin dx = 1; dy = -1; end
      endcase
      r_own = run_len(board_q, x, y, dx, dy, own_c, own_en)
            + run_len(board_q, x, y, -dx, -dy, own_c, own_en);
      r_opp = run_len(board_q, x, y, dx, dy, opp_c, own_en)
            + run_len(board_q, x, y, -dx, -dy, opp_c, own_en);
      m_own = (r_own > WIN_LEN - 1) ? WIN_LEN - 1 : r_own;
      m_opp = (r_opp > WIN_LEN - 1) ? WIN_LEN - 1 : r_opp;
      if (r_own >= WIN_LEN - 1) any_win = 1'b1;
      if (r_opp >= WIN_LEN - 1) any_block = 1'b1;
      base_sum = base_sum + (SUM_W'(2) << (3 * m_own)) + (SUM_W'(1) << (3 * m_opp));
    end
    if (any_win)                             cell_score = SCORE_WIN;
    else if (any_block)                      cell_score = SCORE_BLOCK;
    else if (base_sum > SUM_W'(SCORE_SAT))   cell_score = SCORE_SAT;
    else                                     cell_score = base_sum[SCORE_W-1:0];
  end

  // FSM next-state: start/snapshot, per-cell best tracking, scan termination.
  always_comb begin
    logic take;
    logic last;
    state_d      = state_q;
    board_d      = board_q;
    player_d     = player_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    best_x_d     = best_x_q;
    best_y_d     = best_y_q;
    best_score_d = best_score_q;
    best_valid_d = best_valid_q;
    take         = 1'b0;
    last         = (cx_q == LAST_C) && (cy_q == LAST_C);
    case (state_q)
      SCAN: begin
        // Strictly-greater replacement keeps the lowest index on ties.
        take = cell_empty && (!best_valid_q || (cell_score > best_score_q));
        if (take) begin
          best_x_d     = cx_q;
          best_y_d     = cy_q;
          best_score_d = cell_score;
          best_valid_d = 1'b1;
        end
        if (cx_q == LAST_C) begin
          cx_d = '0;
          cy_d = cy_q + COORD_W'(1);
        end else begin
          cx_d = cx_q + COORD_W'(1);
        end
        // A recorded win cannot be beaten, so stop right away.
        if (last || (take && any_win)) state_d = DONE;
      end
      default: begin
        if (enable_export) begin
          state_d      = SCAN;
          board_d      = board_export;
          player_d     = player_export;
          cx_d         = '0;
          cy_d         = '0;
          best_x_d     = '0;
          best_y_d     = '0;
          best_score_d = '0;
          best_valid_d = 1'b0;
        end
      end
    endcase
  end

  // State registers; reset abandons any scan and clears all results.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q      <= IDLE;
      board_q      <= '0;
      player_q     <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      best_x_q     <= '0;
      best_y_q     <= '0;
      best_score_q <= '0;
      best_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      board_q      <= board_d;
      player_q     <= player_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      best_x_q     <= best_x_d;
      best_y_q     <= best_y_d;
      best_score_q <= best_score_d;
      best_valid_q <= best_valid_d;
    end
  end

  assign outx_export  = best_x_q;
  assign outy_export  = best_y_q;
  assign score_export = best_score_q;
  assign valid_export = best_valid_q;
  assign ready_export = (state_q == DONE);
  assign busy_export  = (state_q == SCAN);

endmodule

// File: tb/tb_gomoku_move_engine.sv
// Testbench for gomoku_move_engine: directed boards, scoreboard queue,
// monitor that checks each result when ready_export rises.
module tb_gomoku_move_engine;

  localparam int N  = 8;
  localparam int CW = 3;
  localparam int WL = 5;
  localparam int SW = 16;
  localparam int BB = 2 * N * N;
  localparam int EW = 39;  // {lat[15:0], valid, score[15:0], x[2:0], y[2:0]}

  // Clock / reset
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [BB-1:0] board = '0;
  logic [1:0]    player = 2'b00;
  logic [CW-1:0] outx;
  logic [CW-1:0] outy;
  logic [SW-1:0] score;
  logic          valid;
  logic          ready;
  logic          busy;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  gomoku_move_engine #(
    .BOARD_N(N), .COORD_W(CW), .WIN_LEN(WL), .SCORE_W(SW)
  ) dut (
    .clk_clk      (clk),
    .reset_reset  (reset),
    .enable_export(enable),
    .board_export (board),
    .player_export(player),
    .outx_export  (outx),
    .outy_export  (outy),
    .score_export (score),
    .valid_export (valid),
    .ready_export (ready),
    .busy_export  (busy)
  );

  // Scoreboard
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  int            start_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares one expected result per rising edge of ready.
  initial begin
    logic          ready_prev;
    logic [EW-1:0] e;
    int            s;
    ready_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (ready && !ready_prev) begin
        if (exp_q.size() == 0) begin
          check("ready_unexpected", 32'(ready), 32'd0);
        end else begin
          e = exp_q.pop_front();
          s = start_q.pop_front();
          check("outx",    32'(outx),  32'(e[5:3]));
          check("outy",    32'(outy),  32'(e[2:0]));
          check("score",   32'(score), 32'(e[21:6]));
          check("valid",   32'(valid), 32'(e[22]));
          check("latency", 32'(cyc - s), 32'(e[38:23]));
          check("busy_done", 32'(busy), 32'd0);
        end
      end
      ready_prev = ready;
    end
  end

  function automatic logic [BB-1:0] put(input logic [BB-1:0] b, input int x, input int y,
                                        input logic [1:0] v);
    b[2*(y*N+x) +: 2] = v;
    return b;
  endfunction

  // Driver: one-cycle start, push expected result, wait (bounded) for it.
  task automatic run(input logic [BB-1:0] b, input logic [1:0] p, input int ex, input int ey,
                     input int escore, input logic ev, input int elat, input bit disturb);
    @(negedge clk);
    board  = b;
    player = p;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    start_q.push_back(cyc);
    exp_q.push_back({16'(elat), ev, 16'(escore), 3'(ex), 3'(ey)});
    check("busy_after_start",  32'(busy),  32'd1);
    check("ready_after_start", 32'(ready), 32'd0);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      if (disturb) begin
        if (i == 0) board = '1;
        enable = (i == 4) || (i == 20) || (i == 21);
      end
    end
    enable = 1'b0;
    if (exp_q.size() != 0) begin
      check("result_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      start_q.delete();
    end
  endtask

  logic [BB-1:0] b_empty, b_win, b_block, b_single, b_full;

  initial begin
    b_empty = '0;
    b_win = '0;
    for (int x = 0; x < 4; x++) b_win = put(b_win, x, 3, 2'b01);
    b_block = '0;
    for (int y = 1; y < 5; y++) b_block = put(b_block, 2, y, 2'b10);
    b_single = put(b_empty, 3, 3, 2'b01);
    b_full = '0;
    for (int y = 0; y < N; y++)
      for (int x = 0; x < N; x++)
        b_full = put(b_full, x, y, ((x + y) % 2 == 1) ? 2'b10 : 2'b01);

    // Reset state
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_outx",  32'(outx),  32'd0);
    check("rst_outy",  32'(outy),  32'd0);
    check("rst_score", 32'(score), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    reset = 1'b0;

    // Empty board: (0,0), 4*(2+1)
    run(b_empty,  2'b01, 0, 0, 12,      1'b1, 64, 1'b0);
    // Four own in a row: early win at idx 28
    run(b_win,    2'b01, 4, 3, 'hFFFF,  1'b1, 29, 1'b0);
    // Four opponent in a column: block, lowest index wins tie
    run(b_block,  2'b01, 2, 0, 'hFFFE,  1'b1, 64, 1'b0);
    // Same board seen by the other colour: immediate win at idx 2
    run(b_block,  2'b10, 2, 0, 'hFFFF,  1'b1, 3,  1'b0);
    // Single own stone: (2,2) scores 17+3*3=26, earliest of the ties
    run(b_single, 2'b01, 2, 2, 26,      1'b1, 64, 1'b0);
    // Full board: no legal move
    run(b_full,   2'b01, 0, 0, 0,       1'b0, 64, 1'b0);
    // Enable pulses in SCAN and board change after start must not matter
    run(b_single, 2'b01, 2, 2, 26,      1'b1, 64, 1'b1);

    // Reset at edge E+10, with enable also high on that edge
    @(negedge clk);
    board  = b_single;
    player = 2'b01;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    repeat (8) @(negedge clk);
    check("mid_busy",  32'(busy),  32'd1);
    check("mid_valid", 32'(valid), 32'd1);
    @(negedge clk);
    reset  = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    reset  = 1'b0;
    enable = 1'b0;
    check("abort_busy",  32'(busy),  32'd0);
    check("abort_ready", 32'(ready), 32'd0);
    check("abort_valid", 32'(valid), 32'd0);
    check("abort_outx",  32'(outx),  32'd0);
    check("abort_outy",  32'(outy),  32'd0);
    check("abort_score", 32'(score), 32'd0);
    repeat (3) @(negedge clk);
    check("idle_busy",  32'(busy),  32'd0);
    check("idle_ready", 32'(ready), 32'd0);

    // Normal operation after the abort
    run(b_empty, 2'b01, 0, 0, 12, 1'b1, 64, 1'b0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
